// File: rtl/pbit_sweep_scheduler.sv
// Purpose: Gibbs sweep sequencer; pulses en one colour class at a time and offers a per-sweep pbit snapshot.
// Latency: first en one cycle after start; sweep period N_COLORS*(1+SETTLE)+1 cycles with sample_ready high.
// Backpressure: sample_valid/sample_ready holds the snapshot stable and stalls the schedule; no en while stalled.
module pbit_sweep_scheduler #(
    parameter int N_PBITS  = 8,
    parameter int N_COLORS = 2,
    parameter int SETTLE   = 2,
    parameter int SWEEP_W  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic                         abort,
    input  logic [SWEEP_W-1:0]           num_sweeps,
    input  logic [N_COLORS*N_PBITS-1:0]  color_mask,
    input  logic [N_PBITS-1:0]           pbit_state,
    output logic [N_PBITS-1:0]           en,
    output logic                         busy,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic [N_PBITS-1:0]           sample_data,
    output logic [SWEEP_W-1:0]           sweep_cnt,
    output logic                         done
);

    localparam int CW = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST_COLOR  = CW'(N_COLORS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 colour;
    logic [SW-1:0]                 settle_cnt;
    logic [SWEEP_W-1:0]            num_q;
    logic [N_COLORS*N_PBITS-1:0]   mask_q;

    logic [CW-1:0]                 colour_nxt;
    logic [N_PBITS-1:0]            nxt_mask;
    logic                          slot_end;
    logic [SWEEP_W-1:0]            sweep_inc;

    // Next-colour mask select and end-of-colour-slot detection
    always_comb begin
        colour_nxt = colour + 1'b1;
        nxt_mask   = '0;
        for (int c = 0; c < N_COLORS; c++) begin
            if (colour_nxt == CW'(c)) begin
                nxt_mask = mask_q[c*N_PBITS +: N_PBITS];
            end
        end
        // With no settle time the colour slot ends on the UPDATE cycle itself
        slot_end  = ((state == S_UPDATE) && (SETTLE == 0)) ||
                    ((state == S_SETTLE) && (settle_cnt == LAST_SETTLE));
        sweep_inc = sweep_cnt + 1'b1;
    end

    // Sweep FSM; every output is registered from the state being entered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            colour       <= '0;
            settle_cnt   <= '0;
            num_q        <= '0;
            mask_q       <= '0;
            en           <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sweep_cnt    <= '0;
            done         <= 1'b0;
        end else begin
            en   <= '0;
            done <= 1'b0;
            if (abort) begin
                // Cancel wins over everything; the partial sweep count is kept
                state        <= S_IDLE;
                busy         <= 1'b0;
                sample_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            num_q      <= num_sweeps;
                            mask_q     <= color_mask;
                            sweep_cnt  <= '0;
                            colour     <= '0;
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            if (num_sweeps == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_UPDATE;
                                en    <= color_mask[N_PBITS-1:0];
                            end
                        end
                    end
                    S_UPDATE, S_SETTLE: begin
                        if (slot_end) begin
                            if (colour != LAST_COLOR) begin
                                colour <= colour_nxt;
                                state  <= S_UPDATE;
                                en     <= nxt_mask;
                            end else begin
                                sample_data  <= pbit_state;
                                sample_valid <= 1'b1;
                                state        <= S_SAMPLE;
                            end
                        end else if (state == S_UPDATE) begin
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (sample_ready) begin
                            sample_valid <= 1'b0;
                            sweep_cnt    <= sweep_inc;
                            if (sweep_inc == num_q) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state  <= S_UPDATE;
                                colour <= '0;
                                en     <= mask_q[N_PBITS-1:0];
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Directed bench for pbit_sweep_scheduler with N=4, two colours, SETTLE=2.
// Cycle t0 is the cycle in which start is presented; tN is N edges later.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pbit_sweep_scheduler;

    localparam int N   = 4;
    localparam int C   = 2;
    localparam int ST  = 2;
    localparam int SWW = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic             abort;
    logic [SWW-1:0]   num_sweeps;
    logic [C*N-1:0]   color_mask;
    logic [N-1:0]     pbit_state;
    logic [N-1:0]     en;
    logic             busy;
    logic             sample_valid;
    logic             sample_ready;
    logic [N-1:0]     sample_data;
    logic [SWW-1:0]   sweep_cnt;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    pbit_sweep_scheduler #(
        .N_PBITS  (N),
        .N_COLORS (C),
        .SETTLE   (ST),
        .SWEEP_W  (SWW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .abort        (abort),
        .num_sweeps   (num_sweeps),
        .color_mask   (color_mask),
        .pbit_state   (pbit_state),
        .en           (en),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sweep_cnt    (sweep_cnt),
        .done         (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps until done is seen; cyc is the number of edges taken, -1 on timeout
    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: done not seen within %0d cycles", tag, budget);
        end
    endtask

    // Single-sweep run with ready high: en@t1/t4, sample@t7, done@t8, idle@t9
    task automatic t1_sequence(input string pfx);
        num_sweeps   = 16'd1;
        sample_ready = 1'b1;
        pbit_state   = 4'h5;
        start        = 1'b1;
        step();                                   // t1
        start = 1'b0;
        chk({pfx, "_en_c0"}, 32'(en), 32'h5);
        chk({pfx, "_busy"}, 32'(busy), 32'h1);
        step();                                   // t2
        chk({pfx, "_en_settle"}, 32'(en), 32'h0);
        step(); step();                           // t4
        chk({pfx, "_en_c1"}, 32'(en), 32'hA);
        step(); step(); step();                   // t7
        chk({pfx, "_valid"}, 32'(sample_valid), 32'h1);
        chk({pfx, "_data"}, 32'(sample_data), 32'h5);
        step();                                   // t8
        chk({pfx, "_done"}, 32'(done), 32'h1);
        chk({pfx, "_cnt"}, 32'(sweep_cnt), 32'h1);
        chk({pfx, "_valid_drop"}, 32'(sample_valid), 32'h0);
        step();                                   // t9
        chk({pfx, "_idle_busy"}, 32'(busy), 32'h0);
        chk({pfx, "_done_pulse"}, 32'(done), 32'h0);
    endtask

    initial begin
        int en_cyc[$];
        logic [N-1:0] en_val[$];
        int samples;
        int done_cyc;
        logic [SWW-1:0] cnt_at_done;
        int cyc;

        RST          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        num_sweeps   = '0;
        color_mask   = 8'hA5;                      // c0 = 0101, c1 = 1010
        pbit_state   = '0;
        sample_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_data", 32'(sample_data), 32'h0);
        chk("rst_cnt", 32'(sweep_cnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        RST = 1'b0;
        step();

        // T1: basic single sweep
        t1_sequence("t1");

        // T2: three sweeps, en period 7, snapshot returns pbit_state
        num_sweeps   = 16'd3;
        pbit_state   = 4'hA;
        sample_ready = 1'b1;
        start        = 1'b1;
        samples      = 0;
        done_cyc     = -1;
        cnt_at_done  = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            start = 1'b0;
            if (en !== '0) begin
                en_cyc.push_back(i);
                en_val.push_back(en);
            end
            if (sample_valid === 1'b1) begin
                samples++;
                chk("t2_data", 32'(sample_data), 32'hA);
            end
            if (done === 1'b1) begin
                done_cyc    = i;
                cnt_at_done = sweep_cnt;
                break;
            end
        end
        chk("t2_en_pulses", 32'(en_cyc.size()), 32'd6);
        chk("t2_period_a", 32'(en_cyc[2] - en_cyc[0]), 32'd7);
        chk("t2_period_b", 32'(en_cyc[4] - en_cyc[2]), 32'd7);
        chk("t2_en_first", 32'(en_val[0]), 32'h5);
        chk("t2_en_second", 32'(en_val[1]), 32'hA);
        chk("t2_samples", 32'(samples), 32'd3);
        chk("t2_done_cyc", 32'(done_cyc), 32'd22);
        chk("t2_cnt", 32'(cnt_at_done), 32'd3);
        step();

        // T3: backpressure holds the snapshot and stalls the schedule
        num_sweeps   = 16'd2;
        pbit_state   = 4'h5;
        sample_ready = 1'b0;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();      // t7
        chk("t3_valid", 32'(sample_valid), 32'h1);
        chk("t3_data", 32'(sample_data), 32'h5);
        pbit_state = 4'h3;
        for (int i = 0; i < 5; i++) begin         // t8..t12
            step();
            chk("t3_hold_valid", 32'(sample_valid), 32'h1);
            chk("t3_hold_data", 32'(sample_data), 32'h5);
            chk("t3_stall_en", 32'(en), 32'h0);
        end
        sample_ready = 1'b1;
        step();                                   // t13
        chk("t3_en_after_hs", 32'(en), 32'h5);
        chk("t3_valid_drop", 32'(sample_valid), 32'h0);
        chk("t3_cnt1", 32'(sweep_cnt), 32'h1);
        wait_done("t3_done", 20, cyc);
        chk("t3_done_cyc", 32'(cyc), 32'd7);
        chk("t3_cnt2", 32'(sweep_cnt), 32'h2);
        chk("t3_data2", 32'(sample_data), 32'h3);
        step();

        // T4: zero sweeps goes straight to DONE
        num_sweeps = 16'd0;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_en", 32'(en), 32'h0);
        chk("t4_valid", 32'(sample_valid), 32'h0);
        step();
        chk("t4_idle", 32'(busy), 32'h0);
        chk("t4_done_drop", 32'(done), 32'h0);
        chk("t4_cnt", 32'(sweep_cnt), 32'h0);

        // T5: abort in SETTLE of sweep 2
        num_sweeps = 16'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();      // t9: SETTLE of sweep 2
        chk("t5_cnt_before", 32'(sweep_cnt), 32'h1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_en", 32'(en), 32'h0);
        chk("t5_valid", 32'(sample_valid), 32'h0);
        chk("t5_cnt_held", 32'(sweep_cnt), 32'h1);
        done_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1 || en !== '0) done_cyc++;
        end
        chk("t5_quiet", 32'(done_cyc), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_restart_cnt", 32'(sweep_cnt), 32'h0);
        chk("t5_restart_en", 32'(en), 32'h5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort2", 32'(busy), 32'h0);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'h0);
        chk("sa_en", 32'(en), 32'h0);

        // T6: asynchronous reset in the middle of UPDATE
        num_sweeps = 16'd1;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("t6_en_pre", 32'(en), 32'h5);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_en_async", 32'(en), 32'h0);
        chk("t6_busy_async", 32'(busy), 32'h0);
        chk("t6_valid_async", 32'(sample_valid), 32'h0);
        step();
        RST = 1'b0;
        step();
        t1_sequence("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
